cache_mem_responder: RTL and testbench

Backing-memory responder for the 2-way write-back cache. It accepts one miss request at a time: a refill of a line, optionally preceded by a writeback of a dirty victim. It stores 32 lines of 3-bit data and returns the refill data with a valid/ready handshake after a programmable access latency. It sits between the cache controller and the top level and stands in for main memory.

---
 rtl/cache_mem_responder_if.sv | 32 +++
 rtl/cache_mem_responder.sv | 121 ++++++++++++
 tb/tb_cache_mem_responder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_responder_if.sv
// cache_mem_responder_if
//   Miss-request / refill-response bundle between the cache controller
//   (master) and the backing-memory responder (slave).
//   req_valid/req_ready   : miss request handshake
//   req_addr              : refill line address {index[1:0], tag[2:0]}
//   req_wb                : dirty victim writeback precedes the refill
//   req_wb_addr/req_wb_data : victim line address and data
//   resp_valid/resp_ready : refill response handshake
//   resp_rdata            : refill data
//   wb_busy               : writeback access in progress
interface cache_mem_responder_if;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_addr;
  logic       req_wb;
  logic [4:0] req_wb_addr;
  logic [2:0] req_wb_data;
  logic       resp_valid;
  logic       resp_ready;
  logic [2:0] resp_rdata;
  logic       wb_busy;

  modport master (
    output req_valid, req_addr, req_wb, req_wb_addr, req_wb_data, resp_ready,
    input  req_ready, resp_valid, resp_rdata, wb_busy
  );

  modport slave (
    input  req_valid, req_addr, req_wb, req_wb_addr, req_wb_data, resp_ready,
    output req_ready, resp_valid, resp_rdata, wb_busy
  );
endinterface

// File: rtl/cache_mem_responder.sv
// cache_mem_responder
//   Backing memory for the 2-way write-back cache: 32 lines x 3 bits.
//   Accepts one miss request at a time, performs an optional victim
//   writeback followed by a refill, each taking LATENCY cycles, and returns
//   the refill data through a valid/ready handshake.
// Parameters:
//   LATENCY : cycles per memory access, 1..15
// Ports:
//   clock   : rising-edge clock
//   reset   : synchronous active-high reset (FSM to IDLE, memory reinit)
//   mem_if  : cache_mem_responder_if.slave request/response bundle
// Optional feature:
//   CACHE_MEM_FWD_EN : when defined, a writeback to the same line as the
//   refill returns the written-back data at WB end and skips FILL.
module cache_mem_responder #(
  parameter int unsigned LATENCY = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  cache_mem_responder_if.slave   mem_if
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_RESP
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [2:0] r_mem [0:31];
  logic [4:0] r_addr;
  logic       r_wb;
  logic [4:0] r_wb_addr;
  logic [2:0] r_wb_data;
  logic [2:0] r_rdata;
  logic       w_acc_done;
  logic       w_fwd;

  assign w_acc_done = (r_cnt == LAST_CNT);

`ifdef CACHE_MEM_FWD_EN
  assign w_fwd = (r_wb_addr == r_addr);
`else
  assign w_fwd = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (mem_if.req_valid) w_next = mem_if.req_wb ? S_WB : S_FILL;
      S_WB:   if (w_acc_done)       w_next = w_fwd ? S_RESP : S_FILL;
      S_FILL: if (w_acc_done)       w_next = S_RESP;
      S_RESP: if (mem_if.resp_ready) w_next = S_IDLE;
      default:                      w_next = S_IDLE;
    endcase
  end

  // Outputs; req_ready is masked by reset so it reads 0 while reset is held
  always_comb begin
    mem_if.req_ready  = (r_state == S_IDLE) && !reset;
    mem_if.resp_valid = (r_state == S_RESP);
    mem_if.wb_busy    = (r_state == S_WB);
    mem_if.resp_rdata = r_rdata;
  end

  // Datapath: request capture, latency counter, memory and response data
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wb      <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_rdata   <= '0;
      for (int unsigned a = 0; a < 32; a++) r_mem[a] <= 3'(a);
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (mem_if.req_valid) begin
            r_addr    <= mem_if.req_addr;
            r_wb      <= mem_if.req_wb;
            r_wb_addr <= mem_if.req_wb_addr;
            r_wb_data <= mem_if.req_wb_data;
          end
        end
        S_WB: begin
          if (w_acc_done) begin
            r_mem[r_wb_addr] <= r_wb_data;
            r_cnt            <= '0;
            if (w_fwd) r_rdata <= r_wb_data;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_FILL: begin
          if (w_acc_done) begin
            r_rdata <= r_mem[r_addr];
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
module tb_cache_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cache_mem_responder_if bus ();

  cache_mem_responder #(.LATENCY(3)) u_dut (
    .clock  (clk),
    .reset  (rst),
    .mem_if (bus.slave)
  );

`ifdef CACHE_MEM_FWD_EN
  localparam int SAME_LAT = 3;
`else
  localparam int SAME_LAT = 6;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue a request at a negedge, then wait (bounded) for resp_valid.
  // lat counts edges after acceptance; busy/rdy count sampled cycles with
  // wb_busy / req_ready high while waiting.
  task automatic run_req(input logic [4:0] a, input logic wb, input logic [4:0] wa,
                         input logic [2:0] wd, output int lat, output int busy,
                         output int rdy, output logic [2:0] data);
    check("req_ready_before_req", bus.req_ready, 1);
    bus.req_addr    = a;
    bus.req_wb      = wb;
    bus.req_wb_addr = wa;
    bus.req_wb_data = wd;
    bus.req_valid   = 1'b1;
    @(negedge clk);
    bus.req_valid   = 1'b0;
    bus.req_addr    = ~a;
    bus.req_wb      = ~wb;
    bus.req_wb_addr = ~wa;
    bus.req_wb_data = ~wd;
    lat = 0; busy = 0; rdy = 0;
    while (bus.resp_valid !== 1'b1 && lat < 40) begin
      if (bus.wb_busy === 1'b1) busy++;
      if (bus.req_ready === 1'b1) rdy++;
      @(negedge clk);
      lat++;
    end
    data = bus.resp_rdata;
  endtask

  task automatic finish_resp(input string tag);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check({tag, "_valid_drop"}, bus.resp_valid, 0);
    check({tag, "_ready_back"}, bus.req_ready, 1);
  endtask

  initial begin
    int         lat, busy, rdy, seen;
    logic [2:0] data;

    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.req_wb      = 1'b0;
    bus.req_wb_addr = '0;
    bus.req_wb_data = '0;
    bus.resp_ready  = 1'b0;

    // Reset defaults
    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_rdata", bus.resp_rdata, 0);
    check("rst_wb_busy", bus.wb_busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", bus.req_ready, 1);
    check("post_rst_resp_valid", bus.resp_valid, 0);

    // Clean refill
    run_req(5'b10011, 1'b0, 5'b00000, 3'b000, lat, busy, rdy, data);
    check("clean_lat", lat, 3);
    check("clean_data", data, 3'b011);
    check("clean_busy", busy, 0);
    check("clean_ready_low", rdy, 0);
    finish_resp("clean");

    // Writeback then refill of a different line
    run_req(5'b00010, 1'b1, 5'b00001, 3'b110, lat, busy, rdy, data);
    check("wb_lat", lat, 6);
    check("wb_data", data, 3'b010);
    check("wb_busy_cycles", busy, 3);
    check("wb_ready_low", rdy, 0);
    finish_resp("wb");
    run_req(5'b00001, 1'b0, 5'b00000, 3'b000, lat, busy, rdy, data);
    check("wb_readback_lat", lat, 3);
    check("wb_readback_data", data, 3'b110);
    finish_resp("wb_readback");

    // Same-line writeback
    run_req(5'b01100, 1'b1, 5'b01100, 3'b101, lat, busy, rdy, data);
    check("same_lat", lat, SAME_LAT);
    check("same_data", data, 3'b101);
    check("same_busy_cycles", busy, 3);
    finish_resp("same");
    run_req(5'b01100, 1'b0, 5'b00000, 3'b000, lat, busy, rdy, data);
    check("same_readback_data", data, 3'b101);
    finish_resp("same_readback");

    // Response stall with ignored request pulses
    run_req(5'b00111, 1'b0, 5'b00000, 3'b000, lat, busy, rdy, data);
    check("stall_data", data, 3'b111);
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = (i % 2 == 0);
      bus.req_addr  = 5'b11110;
      bus.req_wb    = 1'b1;
      @(negedge clk);
      check("stall_valid_hold", bus.resp_valid, 1);
      check("stall_rdata_hold", bus.resp_rdata, 3'b111);
      check("stall_ready_low", bus.req_ready, 0);
    end
    bus.req_valid = 1'b0;
    finish_resp("stall");
    @(negedge clk);
    check("stall_no_new_busy", bus.wb_busy, 0);

    // resp_ready already high on RESP entry: one-cycle response
    bus.resp_ready = 1'b1;
    run_req(5'b01101, 1'b0, 5'b00000, 3'b000, lat, busy, rdy, data);
    check("oneshot_lat", lat, 3);
    check("oneshot_data", data, 3'b101);
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("oneshot_valid_drop", bus.resp_valid, 0);
    check("oneshot_ready_back", bus.req_ready, 1);

    // Reset in the second WB cycle
    bus.req_addr    = 5'b00110;
    bus.req_wb      = 1'b1;
    bus.req_wb_addr = 5'b00101;
    bus.req_wb_data = 3'b010;
    bus.req_valid   = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("midwb_busy1", bus.wb_busy, 1);
    @(negedge clk);
    check("midwb_busy2", bus.wb_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midwb_rst_busy", bus.wb_busy, 0);
    check("midwb_rst_ready", bus.req_ready, 0);
    check("midwb_rst_rdata", bus.resp_rdata, 0);
    rst = 1'b0;
    bus.resp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) seen++;
    end
    bus.resp_ready = 1'b0;
    check("midwb_no_resp", seen, 0);
    run_req(5'b00101, 1'b0, 5'b00000, 3'b000, lat, busy, rdy, data);
    check("midwb_mem_lat", lat, 3);
    check("midwb_mem_data", data, 3'b101);
    finish_resp("midwb");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
